// File: rtl/id_ex_stage_if.sv
// ID-to-EX bundle: decoded fields coming in from ID and the registered copies handed on to EX.
// master drives ID and consumes EX (decode side); slave is the pipeline register itself.
interface id_ex_stage_if #(
    parameter int CTRL_W = 16
) ();
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [31:0]       id_imm;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic [4:0]        id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic [CTRL_W-1:0] id_ctrl;

    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_imm;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic [31:0]       ex_rs1_val;
    logic [31:0]       ex_rs2_val;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [CTRL_W-1:0] ex_ctrl;

    modport master (
        output id_valid, id_pc, id_imm, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_reg_write, id_mem_read, id_ctrl,
        input  ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_rs1_val, ex_rs2_val,
               ex_reg_write, ex_mem_read, ex_ctrl
    );

    modport slave (
        input  id_valid, id_pc, id_imm, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_reg_write, id_mem_read, id_ctrl,
        output ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_rs1_val, ex_rs2_val,
               ex_reg_write, ex_mem_read, ex_ctrl
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use bubble insertion,
// EX stall hold (with held-operand refresh) and branch flush.
module id_ex_stage #(
    parameter int CTRL_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    id_ex_stage_if.slave pipe,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_wd,
    input  logic        ex_stall,
    input  logic        ex_flush,
    output logic        stall_id,
    output logic [31:0] bubble_cnt
);
    logic              ex_valid_q, ex_valid_d;
    logic [31:0]       ex_pc_q, ex_pc_d;
    logic [31:0]       ex_imm_q, ex_imm_d;
    logic [4:0]        ex_rs1_q, ex_rs1_d;
    logic [4:0]        ex_rs2_q, ex_rs2_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic [31:0]       ex_rs1_val_q, ex_rs1_val_d;
    logic [31:0]       ex_rs2_val_q, ex_rs2_val_d;
    logic              ex_reg_write_q, ex_reg_write_d;
    logic              ex_mem_read_q, ex_mem_read_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [31:0]       bubble_cnt_q, bubble_cnt_d;

    logic [31:0] op1, op2;
    logic        wb_live, load_use;

    // RF writes land on the edge, so a same-cycle read still sees the old value.
    assign wb_live = wb_we && (wb_rd != 5'd0);
    assign op1     = (wb_live && wb_rd == pipe.id_rs1) ? wb_wd : rf_rd1;
    assign op2     = (wb_live && wb_rd == pipe.id_rs2) ? wb_wd : rf_rd2;

    assign load_use = ex_valid_q && ex_mem_read_q && (ex_rd_q != 5'd0) && pipe.id_valid &&
                      ((pipe.id_uses_rs1 && pipe.id_rs1 == ex_rd_q) ||
                       (pipe.id_uses_rs2 && pipe.id_rs2 == ex_rd_q));

    // Gated by reset so ID is released immediately when reset hits mid-stall.
    assign stall_id = rst && !ex_flush && (load_use || ex_stall);

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_pc_d        = ex_pc_q;
        ex_imm_d       = ex_imm_q;
        ex_rs1_d       = ex_rs1_q;
        ex_rs2_d       = ex_rs2_q;
        ex_rd_d        = ex_rd_q;
        ex_rs1_val_d   = ex_rs1_val_q;
        ex_rs2_val_d   = ex_rs2_val_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_ctrl_d      = ex_ctrl_q;
        bubble_cnt_d   = bubble_cnt_q;
        if (ex_flush) begin
            ex_valid_d     = 1'b0;
            ex_pc_d        = '0;
            ex_imm_d       = '0;
            ex_rs1_d       = '0;
            ex_rs2_d       = '0;
            ex_rd_d        = '0;
            ex_rs1_val_d   = '0;
            ex_rs2_val_d   = '0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_ctrl_d      = '0;
        end else if (ex_stall) begin
            if (ex_valid_q && wb_live && wb_rd == ex_rs1_q) ex_rs1_val_d = wb_wd;
            if (ex_valid_q && wb_live && wb_rd == ex_rs2_q) ex_rs2_val_d = wb_wd;
        end else if (load_use) begin
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            if (bubble_cnt_q != 32'hFFFF_FFFF) bubble_cnt_d = bubble_cnt_q + 32'd1;
        end else begin
            ex_valid_d     = pipe.id_valid;
            ex_pc_d        = pipe.id_pc;
            ex_imm_d       = pipe.id_imm;
            ex_rs1_d       = pipe.id_rs1;
            ex_rs2_d       = pipe.id_rs2;
            ex_rd_d        = pipe.id_rd;
            ex_rs1_val_d   = op1;
            ex_rs2_val_d   = op2;
            ex_reg_write_d = pipe.id_reg_write && pipe.id_valid;
            ex_mem_read_d  = pipe.id_mem_read && pipe.id_valid;
            ex_ctrl_d      = pipe.id_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q     <= 1'b0;
            ex_pc_q        <= '0;
            ex_imm_q       <= '0;
            ex_rs1_q       <= '0;
            ex_rs2_q       <= '0;
            ex_rd_q        <= '0;
            ex_rs1_val_q   <= '0;
            ex_rs2_val_q   <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_ctrl_q      <= '0;
            bubble_cnt_q   <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_pc_q        <= ex_pc_d;
            ex_imm_q       <= ex_imm_d;
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            ex_rd_q        <= ex_rd_d;
            ex_rs1_val_q   <= ex_rs1_val_d;
            ex_rs2_val_q   <= ex_rs2_val_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_ctrl_q      <= ex_ctrl_d;
            bubble_cnt_q   <= bubble_cnt_d;
        end
    end

    assign pipe.ex_valid     = ex_valid_q;
    assign pipe.ex_pc        = ex_pc_q;
    assign pipe.ex_imm       = ex_imm_q;
    assign pipe.ex_rs1       = ex_rs1_q;
    assign pipe.ex_rs2       = ex_rs2_q;
    assign pipe.ex_rd        = ex_rd_q;
    assign pipe.ex_rs1_val   = ex_rs1_val_q;
    assign pipe.ex_rs2_val   = ex_rs2_val_q;
    assign pipe.ex_reg_write = ex_reg_write_q;
    assign pipe.ex_mem_read  = ex_mem_read_q;
    assign pipe.ex_ctrl      = ex_ctrl_q;
    assign bubble_cnt        = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: an instruction-level model of the EX slot is checked
// every cycle, alongside literal expectations for the key scenarios.
module tb_id_ex_stage;
    localparam int CTRL_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] rf_rd1 = '0, rf_rd2 = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_wd = '0;
    logic        ex_stall = 1'b0, ex_flush = 1'b0;
    logic        stall_id;
    logic [31:0] bubble_cnt;

    int total = 0;
    int bad   = 0;

    id_ex_stage_if #(.CTRL_W(CTRL_W)) pipe ();

    id_ex_stage #(.CTRL_W(CTRL_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe       (pipe),
        .rf_rd1     (rf_rd1),
        .rf_rd2     (rf_rd2),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_wd      (wb_wd),
        .ex_stall   (ex_stall),
        .ex_flush   (ex_flush),
        .stall_id   (stall_id),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    // Model of the instruction occupying EX.
    typedef struct {
        bit              valid;
        bit [31:0]       pc, imm;
        bit [4:0]        rs1, rs2, rd;
        bit [31:0]       v1, v2;
        bit              rw, mr;
        bit [CTRL_W-1:0] ctrl;
    } ex_slot_t;

    ex_slot_t  m = '{default: '0};
    bit [31:0] m_bubbles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit [31:0] reg_read(input bit [4:0] idx, input bit [31:0] rf_val);
        // The value the instruction should see: a register written this cycle has its new value.
        if (wb_we && wb_rd != 0 && wb_rd == idx) return wb_wd;
        return rf_val;
    endfunction

    function automatic bit depends_on_load();
        bit hit;
        hit = 0;
        if (m.valid && m.mr && m.rd != 0 && pipe.id_valid) begin
            if (pipe.id_uses_rs1 && pipe.id_rs1 == m.rd) hit = 1;
            if (pipe.id_uses_rs2 && pipe.id_rs2 == m.rd) hit = 1;
        end
        return hit;
    endfunction

    function automatic bit exp_stall_id();
        if (!rst || ex_flush) return 0;
        return ex_stall || depends_on_load();
    endfunction

    task automatic model_edge();
        ex_slot_t n;
        n = m;
        if (ex_flush) begin
            n = '{default: '0};
        end else if (ex_stall) begin
            if (m.valid && wb_we && wb_rd != 0) begin
                if (wb_rd == m.rs1) n.v1 = wb_wd;
                if (wb_rd == m.rs2) n.v2 = wb_wd;
            end
        end else if (depends_on_load()) begin
            n.valid = 0; n.rw = 0; n.mr = 0;
            if (m_bubbles != 32'hFFFF_FFFF) m_bubbles = m_bubbles + 1;
        end else begin
            n.valid = pipe.id_valid;
            n.pc    = pipe.id_pc;
            n.imm   = pipe.id_imm;
            n.rs1   = pipe.id_rs1;
            n.rs2   = pipe.id_rs2;
            n.rd    = pipe.id_rd;
            n.v1    = reg_read(pipe.id_rs1, rf_rd1);
            n.v2    = reg_read(pipe.id_rs2, rf_rd2);
            n.rw    = pipe.id_valid && pipe.id_reg_write;
            n.mr    = pipe.id_valid && pipe.id_mem_read;
            n.ctrl  = pipe.id_ctrl;
        end
        m = n;
    endtask

    task automatic check_all();
        chk("ex_valid",     pipe.ex_valid,     m.valid);
        chk("ex_pc",        pipe.ex_pc,        m.pc);
        chk("ex_imm",       pipe.ex_imm,       m.imm);
        chk("ex_rs1",       pipe.ex_rs1,       m.rs1);
        chk("ex_rs2",       pipe.ex_rs2,       m.rs2);
        chk("ex_rd",        pipe.ex_rd,        m.rd);
        chk("ex_rs1_val",   pipe.ex_rs1_val,   m.v1);
        chk("ex_rs2_val",   pipe.ex_rs2_val,   m.v2);
        chk("ex_reg_write", pipe.ex_reg_write, m.rw);
        chk("ex_mem_read",  pipe.ex_mem_read,  m.mr);
        chk("ex_ctrl",      pipe.ex_ctrl,      m.ctrl);
        chk("bubble_cnt",   bubble_cnt,        m_bubbles);
        chk("stall_id",     stall_id,          exp_stall_id());
    endtask

    always @(negedge rst) begin
        m = '{default: '0};
        m_bubbles = 0;
    end

    always @(posedge clk) begin
        if (rst) model_edge();
        #1;
        if (rst) check_all();
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input bit v, input bit [31:0] pc, input bit [4:0] rs1, input bit [4:0] rs2,
                          input bit u1, input bit u2, input bit [4:0] rd, input bit rw, input bit mr,
                          input bit [31:0] d1, input bit [31:0] d2, input bit [15:0] ctrl);
        pipe.id_valid     = v;
        pipe.id_pc        = pc;
        pipe.id_imm       = pc ^ 32'h0000_0F00;
        pipe.id_rs1       = rs1;
        pipe.id_rs2       = rs2;
        pipe.id_uses_rs1  = u1;
        pipe.id_uses_rs2  = u2;
        pipe.id_rd        = rd;
        pipe.id_reg_write = rw;
        pipe.id_mem_read  = mr;
        pipe.id_ctrl      = ctrl;
        rf_rd1            = d1;
        rf_rd2            = d2;
    endtask

    initial begin
        set_id(1, 32'h10, 5'd1, 5'd0, 1, 0, 5'd2, 1, 0, 32'd5, 32'd0, 16'h0001);
        #17;
        chk("rst_ex_valid",   pipe.ex_valid,   0);
        chk("rst_ex_pc",      pipe.ex_pc,      0);
        chk("rst_ex_rs1_val", pipe.ex_rs1_val, 0);
        chk("rst_bubble_cnt", bubble_cnt,      0);
        chk("rst_stall_id",   stall_id,        0);
        rst = 1'b1;
        cyc();
        chk("first_ex_valid",   pipe.ex_valid,   1);
        chk("first_ex_pc",      pipe.ex_pc,      32'h10);
        chk("first_ex_rs1_val", pipe.ex_rs1_val, 32'd5);

        // Same-cycle writeback bypass, rs1 then x0 then rs2.
        set_id(1, 32'h14, 5'd3, 5'd4, 1, 1, 5'd6, 1, 0, 32'h1111, 32'h4444, 16'h0002);
        wb_we = 1; wb_rd = 5'd3; wb_wd = 32'hABCD;
        cyc();
        chk("bypass_rs1", pipe.ex_rs1_val, 32'hABCD);
        chk("nobypass_rs2", pipe.ex_rs2_val, 32'h4444);
        set_id(1, 32'h18, 5'd0, 5'd0, 1, 0, 5'd6, 1, 0, 32'h0, 32'h0, 16'h0003);
        wb_rd = 5'd0; wb_wd = 32'h9999;
        cyc();
        chk("x0_never_bypassed", pipe.ex_rs1_val, 32'h0);
        set_id(1, 32'h1C, 5'd1, 5'd9, 1, 1, 5'd6, 1, 0, 32'h1, 32'h2222, 16'h0004);
        wb_rd = 5'd9; wb_wd = 32'h77;
        cyc();
        chk("bypass_rs2", pipe.ex_rs2_val, 32'h77);
        wb_we = 0;

        // Load x5 then dependent add on rs2: exactly one bubble.
        set_id(1, 32'h20, 5'd2, 5'd0, 1, 0, 5'd5, 1, 1, 32'h100, 32'h0, 16'h0010);
        cyc();
        set_id(1, 32'h24, 5'd6, 5'd5, 1, 1, 5'd7, 1, 0, 32'h1, 32'h2, 16'h0011);
        #1;
        chk("lu_stall_id", stall_id, 1);
        cyc();
        chk("lu_bubble_valid", pipe.ex_valid, 0);
        chk("lu_bubble_cnt",   bubble_cnt,    1);
        chk("lu_stall_drops",  stall_id,      0);
        cyc();
        chk("lu_add_valid", pipe.ex_valid, 1);
        chk("lu_add_pc",    pipe.ex_pc,    32'h24);

        // Same pair but the add does not read rs2.
        set_id(1, 32'h30, 5'd2, 5'd0, 1, 0, 5'd5, 1, 1, 32'h100, 32'h0, 16'h0012);
        cyc();
        set_id(1, 32'h34, 5'd6, 5'd5, 1, 0, 5'd7, 1, 0, 32'h1, 32'h2, 16'h0013);
        #1;
        chk("nolu_stall_id", stall_id, 0);
        cyc();
        chk("nolu_pc",  pipe.ex_pc, 32'h34);
        chk("nolu_cnt", bubble_cnt, 1);

        // Flush dominates a load-use.
        set_id(1, 32'h40, 5'd2, 5'd0, 1, 0, 5'd5, 1, 1, 32'h100, 32'h0, 16'h0014);
        cyc();
        set_id(1, 32'h44, 5'd6, 5'd5, 1, 1, 5'd7, 1, 0, 32'h1, 32'h2, 16'h0015);
        ex_flush = 1;
        #1;
        chk("flush_stall_id", stall_id, 0);
        cyc();
        chk("flush_valid", pipe.ex_valid, 0);
        chk("flush_cnt",   bubble_cnt,    1);
        ex_flush = 0;

        // EX stall for 3 cycles with a writeback to the held rs2.
        set_id(1, 32'h50, 5'd4, 5'd7, 1, 1, 5'd8, 1, 0, 32'h10, 32'h20, 16'hBEEF);
        cyc();
        set_id(1, 32'h54, 5'd1, 5'd2, 1, 1, 5'd9, 1, 0, 32'hA, 32'hB, 16'h0020);
        ex_stall = 1; wb_we = 1; wb_rd = 5'd7; wb_wd = 32'h55;
        #1;
        chk("stall_stall_id", stall_id, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc",       pipe.ex_pc,         32'h50);
            chk("stall_rs1_val",  pipe.ex_rs1_val,    32'h10);
            chk("stall_rs2_val",  pipe.ex_rs2_val,    32'h55);
            chk("stall_ctrl",     pipe.ex_ctrl,       16'hBEEF);
        end
        ex_stall = 0; wb_we = 0;
        cyc();
        chk("release_pc",  pipe.ex_pc,      32'h54);
        chk("release_rs1", pipe.ex_rs1_val, 32'hA);

        // Async reset in the middle of a stall.
        set_id(1, 32'h60, 5'd1, 5'd2, 1, 1, 5'd3, 1, 1, 32'h6, 32'h7, 16'h0030);
        cyc();
        ex_stall = 1;
        #1;
        chk("pre_rst_stall_id", stall_id, 1);
        rst = 1'b0;
        #1;
        chk("arst_valid",    pipe.ex_valid,     0);
        chk("arst_pc",       pipe.ex_pc,        0);
        chk("arst_mem_read", pipe.ex_mem_read,  0);
        chk("arst_cnt",      bubble_cnt,        0);
        chk("arst_stall_id", stall_id,          0);
        #10;
        rst = 1'b1;
        ex_stall = 0;
        cyc();
        chk("after_rst_pc", pipe.ex_pc, 32'h60);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
